// File: rtl/cclut_position_builder.sv
// Refines the two best CLCT candidates into halfstrip/quarter/eighth-strip positions using the LUT offset/bend words.
// Optional statistics counters are enabled by defining CCLUT_POS_STATS_EN.
module cclut_position_builder #(
    parameter int MXHS    = 224,
    parameter int MXKEYBX = 8,
    parameter int MXPIDB  = 4,
    parameter int MXOFFSB = 4,
    parameter int MXBNDB  = 5,
    parameter int MXESB   = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                vld0_in,
    input  logic                vld1_in,
    input  logic [MXKEYBX-1:0]  key0_in,
    input  logic [MXKEYBX-1:0]  key1_in,
    input  logic [MXPIDB-1:0]   pid0_in,
    input  logic [MXPIDB-1:0]   pid1_in,
    input  logic [MXOFFSB-1:0]  offs0,
    input  logic [MXOFFSB-1:0]  offs1,
    input  logic [MXBNDB-1:0]   bend0,
    input  logic [MXBNDB-1:0]   bend1,
    output logic                clct0_vld,
    output logic                clct1_vld,
    output logic [MXKEYBX-1:0]  clct0_hs,
    output logic [MXKEYBX-1:0]  clct1_hs,
    output logic                clct0_qs,
    output logic                clct1_qs,
    output logic                clct0_es,
    output logic                clct1_es,
    output logic [MXBNDB-1:0]   clct0_bend,
    output logic [MXBNDB-1:0]   clct1_bend,
    output logic [MXPIDB-1:0]   clct0_pid,
    output logic [MXPIDB-1:0]   clct1_pid,
    output logic                clamp0,
    output logic                clamp1,
    output logic                lut_miss0,
    output logic                lut_miss1,
    output logic                dup_flag,
    input  logic                stat_clr,
    output logic [15:0]         stat_clamp_cnt,
    output logic [15:0]         stat_miss_cnt
);

    localparam int ESW = MXESB + 2;
    localparam logic signed [ESW-1:0] ES_MAX    = ESW'(4 * MXHS - 1);
    localparam logic signed [ESW-1:0] OFFS_ZERO = ESW'(7);

    logic [1:0]           vld_bus;
    logic [2*MXKEYBX-1:0] key_bus;
    logic [2*MXPIDB-1:0]  pid_bus;
    logic [2*MXOFFSB-1:0] offs_bus;
    logic [2*MXBNDB-1:0]  bend_bus;

    assign vld_bus  = {vld1_in, vld0_in};
    assign key_bus  = {key1_in, key0_in};
    assign pid_bus  = {pid1_in, pid0_in};
    assign offs_bus = {offs1, offs0};
    assign bend_bus = {bend1, bend0};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cand
            logic                    vld_a_reg;
            logic [MXKEYBX-1:0]      key_a_reg;
            logic [MXPIDB-1:0]       pid_a_reg;
            logic signed [ESW-1:0]   es_raw;
            logic [MXOFFSB-1:0]      offs_eff;
            logic [MXESB-1:0]        es_b;
            logic [MXBNDB-1:0]       bend_b;
            logic [MXPIDB-1:0]       pid_b;
            logic                    clamp_b;
            logic                    miss_b;
            logic                    vld_c_reg;
            logic [MXESB-1:0]        es_c_reg;
            logic [MXBNDB-1:0]       bend_c_reg;
            logic [MXPIDB-1:0]       pid_c_reg;
            logic                    clamp_c_reg;
            logic                    miss_c_reg;

            // Candidate fields arrive one cycle ahead of the LUT words, so they are aligned here.
            always_ff @(posedge clock) begin
                if (reset) begin
                    vld_a_reg <= 1'b0;
                    key_a_reg <= '0;
                    pid_a_reg <= '0;
                end else begin
                    vld_a_reg <= vld_bus[gi];
                    key_a_reg <= key_bus[gi*MXKEYBX +: MXKEYBX];
                    pid_a_reg <= pid_bus[gi*MXPIDB +: MXPIDB];
                end
            end

            always_comb begin
                offs_eff = offs_bus[gi*MXOFFSB +: MXOFFSB];
                bend_b   = bend_bus[gi*MXBNDB +: MXBNDB];
                pid_b    = pid_a_reg;
                miss_b   = 1'b0;
                clamp_b  = 1'b0;
                // Pattern IDs beyond the LUT fall back to the centred offset with no bend.
                if (pid_a_reg > MXPIDB'(4)) begin
                    offs_eff = MXOFFSB'(7);
                    bend_b   = '0;
                    miss_b   = 1'b1;
                end
                es_raw = ESW'({key_a_reg, 2'b00}) + ESW'(offs_eff) - OFFS_ZERO;
                es_b   = es_raw[MXESB-1:0];
                if (es_raw[ESW-1]) begin
                    es_b    = '0;
                    clamp_b = 1'b1;
                end else if (es_raw > ES_MAX) begin
                    es_b    = ES_MAX[MXESB-1:0];
                    clamp_b = 1'b1;
                end
                if (!vld_a_reg) begin
                    es_b    = '0;
                    bend_b  = '0;
                    pid_b   = '0;
                    miss_b  = 1'b0;
                    clamp_b = 1'b0;
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    vld_c_reg   <= 1'b0;
                    es_c_reg    <= '0;
                    bend_c_reg  <= '0;
                    pid_c_reg   <= '0;
                    clamp_c_reg <= 1'b0;
                    miss_c_reg  <= 1'b0;
                end else begin
                    vld_c_reg   <= vld_a_reg;
                    es_c_reg    <= es_b;
                    bend_c_reg  <= bend_b;
                    pid_c_reg   <= pid_b;
                    clamp_c_reg <= clamp_b;
                    miss_c_reg  <= miss_b;
                end
            end
        end
    endgenerate

    logic dup_b;
    logic dup_c_reg;

    assign dup_b = g_cand[0].vld_a_reg & g_cand[1].vld_a_reg & (g_cand[0].es_b == g_cand[1].es_b);

    always_ff @(posedge clock) begin
        if (reset) begin
            dup_c_reg <= 1'b0;
        end else begin
            dup_c_reg <= dup_b;
        end
    end

    assign clct0_vld  = g_cand[0].vld_c_reg;
    assign clct1_vld  = g_cand[1].vld_c_reg;
    assign clct0_hs   = g_cand[0].es_c_reg[MXESB-1:2];
    assign clct1_hs   = g_cand[1].es_c_reg[MXESB-1:2];
    assign clct0_qs   = g_cand[0].es_c_reg[1];
    assign clct1_qs   = g_cand[1].es_c_reg[1];
    assign clct0_es   = g_cand[0].es_c_reg[0];
    assign clct1_es   = g_cand[1].es_c_reg[0];
    assign clct0_bend = g_cand[0].bend_c_reg;
    assign clct1_bend = g_cand[1].bend_c_reg;
    assign clct0_pid  = g_cand[0].pid_c_reg;
    assign clct1_pid  = g_cand[1].pid_c_reg;
    assign clamp0     = g_cand[0].clamp_c_reg;
    assign clamp1     = g_cand[1].clamp_c_reg;
    assign lut_miss0  = g_cand[0].miss_c_reg;
    assign lut_miss1  = g_cand[1].miss_c_reg;
    assign dup_flag   = dup_c_reg;

`ifdef CCLUT_POS_STATS_EN
    logic [15:0] clamp_cnt_reg;
    logic [15:0] miss_cnt_reg;
    logic [1:0]  clamp_inc;
    logic [1:0]  miss_inc;

    function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + 17'(inc);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    assign clamp_inc = {1'b0, clamp0} + {1'b0, clamp1};
    assign miss_inc  = {1'b0, lut_miss0} + {1'b0, lut_miss1};

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clock) begin
        if (reset || stat_clr) begin
            clamp_cnt_reg <= '0;
            miss_cnt_reg  <= '0;
        end else begin
            clamp_cnt_reg <= sat_add(clamp_cnt_reg, clamp_inc);
            miss_cnt_reg  <= sat_add(miss_cnt_reg, miss_inc);
        end
    end

    assign stat_clamp_cnt = clamp_cnt_reg;
    assign stat_miss_cnt  = miss_cnt_reg;
`else
    logic stat_clr_unused;
    assign stat_clr_unused = stat_clr;
    assign stat_clamp_cnt  = '0;
    assign stat_miss_cnt   = '0;
`endif

endmodule
